// File: rtl/mw_pipeline_stage.sv
// MEM->WB pipeline stage: DEPTH register slices with stall/flush, valid tracking,
// write-back data select and register-file forwarding hit detection.
module mw_pipeline_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [ADDR_WIDTH-1:0] write_reg_addr,
  input  logic                  reg_write,
  input  logic                  mem_reg,
  input  logic [ADDR_WIDTH-1:0] fwd_rs_addr,
  input  logic [ADDR_WIDTH-1:0] fwd_rt_addr,
  output logic [DATA_WIDTH-1:0] mem_read_data_buffered,
  output logic [DATA_WIDTH-1:0] alu_result_buffered,
  output logic [ADDR_WIDTH-1:0] write_reg_addr_buffered,
  output logic                  reg_write_buffered,
  output logic                  mem_reg_buffered,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("mw_pipeline_stage: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] mem;
    logic [DATA_WIDTH-1:0] alu;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic                  mr;
  } slice_t;

  slice_t in_slice;
  slice_t pipe_q [DEPTH];
  slice_t pipe_d [DEPTH];
  slice_t last;
  logic   suppress;

  always_comb begin
    in_slice       = '0;
    in_slice.valid = in_valid;
    in_slice.mem   = mem_read_data;
    in_slice.alu   = alu_result;
    in_slice.addr  = write_reg_addr;
    in_slice.rw    = reg_write & in_valid;
    in_slice.mr    = mem_reg;
  end

  // Flush is checked first so it overrides stall; data fields are left as-is.
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        pipe_d[k].valid = 1'b0;
        pipe_d[k].rw    = 1'b0;
      end
    end else if (!stall) begin
      pipe_d[0] = in_slice;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign last     = pipe_q[DEPTH-1];
  assign suppress = (ZERO_REG != 0) && (last.addr == '0);

  assign mem_read_data_buffered  = last.mem;
  assign alu_result_buffered     = last.alu;
  assign write_reg_addr_buffered = last.addr;
  assign mem_reg_buffered        = last.mr;
  assign out_valid               = last.valid;
  assign reg_write_buffered      = last.rw & last.valid & ~suppress;

  always_comb begin
    wb_data = '0;
    if (last.valid) begin
      wb_data = last.mr ? last.mem : last.alu;
    end
  end

  assign fwd_rs_hit = reg_write_buffered & (last.addr == fwd_rs_addr);
  assign fwd_rt_hit = reg_write_buffered & (last.addr == fwd_rt_addr);

endmodule

// File: tb/tb_mw_pipeline_stage.sv
// Directed bench for mw_pipeline_stage: DEPTH=1 and DEPTH=3 with r0 suppression,
// plus a DEPTH=1 instance without r0 suppression, all sharing one input stream.
module tb_mw_pipeline_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, in_valid, reg_write, mem_reg;
  logic [DW-1:0] mem_read_data, alu_result;
  logic [AW-1:0] write_reg_addr, fwd_rs_addr, fwd_rt_addr;

  logic [DW-1:0] d1_mem, d1_alu, d1_wb, d3_mem, d3_alu, d3_wb, z0_mem, z0_alu, z0_wb;
  logic [AW-1:0] d1_addr, d3_addr, z0_addr;
  logic d1_rwb, d1_mr, d1_ov, d1_rs, d1_rt;
  logic d3_rwb, d3_mr, d3_ov, d3_rs, d3_rt;
  logic z0_rwb, z0_mr, z0_ov, z0_rs, z0_rt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mw_pipeline_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1), .ZERO_REG(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_read_data(mem_read_data), .alu_result(alu_result), .write_reg_addr(write_reg_addr),
    .reg_write(reg_write), .mem_reg(mem_reg), .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr),
    .mem_read_data_buffered(d1_mem), .alu_result_buffered(d1_alu),
    .write_reg_addr_buffered(d1_addr), .reg_write_buffered(d1_rwb), .mem_reg_buffered(d1_mr),
    .out_valid(d1_ov), .wb_data(d1_wb), .fwd_rs_hit(d1_rs), .fwd_rt_hit(d1_rt));

  mw_pipeline_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(3), .ZERO_REG(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_read_data(mem_read_data), .alu_result(alu_result), .write_reg_addr(write_reg_addr),
    .reg_write(reg_write), .mem_reg(mem_reg), .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr),
    .mem_read_data_buffered(d3_mem), .alu_result_buffered(d3_alu),
    .write_reg_addr_buffered(d3_addr), .reg_write_buffered(d3_rwb), .mem_reg_buffered(d3_mr),
    .out_valid(d3_ov), .wb_data(d3_wb), .fwd_rs_hit(d3_rs), .fwd_rt_hit(d3_rt));

  mw_pipeline_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_read_data(mem_read_data), .alu_result(alu_result), .write_reg_addr(write_reg_addr),
    .reg_write(reg_write), .mem_reg(mem_reg), .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr),
    .mem_read_data_buffered(z0_mem), .alu_result_buffered(z0_alu),
    .write_reg_addr_buffered(z0_addr), .reg_write_buffered(z0_rwb), .mem_reg_buffered(z0_mr),
    .out_valid(z0_ov), .wb_data(z0_wb), .fwd_rs_hit(z0_rs), .fwd_rt_hit(z0_rt));

  // Stream table for the DEPTH=3 instance: op presented, stall, op expected at output.
  int unsigned s_op  [11] = '{1, 2, 3, 4, 5, 5, 5, 6, 0, 0, 0};
  logic        s_stl [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  int unsigned s_exp [11] = '{0, 0, 1, 2, 2, 2, 3, 4, 5, 6, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [DW-1:0] m, input logic [DW-1:0] a,
                     input logic [AW-1:0] ad, input logic rw, input logic mr);
    in_valid       = v;
    mem_read_data  = m;
    alu_result     = a;
    write_reg_addr = ad;
    reg_write      = rw;
    mem_reg        = mr;
  endtask

  task automatic put_op(input int unsigned op);
    put(1'b1, 32'hAAAA0000 + op, 32'h100 + op, AW'(op), 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string who, input logic ov, input logic rwb, input logic [DW-1:0] wb,
                          input logic [AW-1:0] ad, input logic [DW-1:0] al, input logic [DW-1:0] me,
                          input logic rs, input logic rt);
    chk({who, "_ov"}, ov, 0);
    chk({who, "_rwb"}, rwb, 0);
    chk({who, "_wb"}, wb, 0);
    chk({who, "_addr"}, ad, 0);
    chk({who, "_alu"}, al, 0);
    chk({who, "_mem"}, me, 0);
    chk({who, "_rs"}, rs, 0);
    chk({who, "_rt"}, rt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    put(1'b1, $urandom, $urandom, AW'($urandom_range(0, 31)), 1'b1, 1'b1);
    fwd_rs_addr = AW'($urandom_range(0, 31));
    fwd_rt_addr = AW'($urandom_range(0, 31));
    #1 rst_n = 1'b0;
    #2;
    chk_zero("rst_d1", d1_ov, d1_rwb, d1_wb, d1_addr, d1_alu, d1_mem, d1_rs, d1_rt);
    chk_zero("rst_d3", d3_ov, d3_rwb, d3_wb, d3_addr, d3_alu, d3_mem, d3_rs, d3_rt);
    chk_zero("rst_z0", z0_ov, z0_rwb, z0_wb, z0_addr, z0_alu, z0_mem, z0_rs, z0_rt);
    tick();
    put(1'b1, $urandom, $urandom, AW'($urandom_range(1, 31)), 1'b1, 1'b0);
    tick();
    chk("rst_hold_d1_ov", d1_ov, 0);
    chk("rst_hold_d3_rwb", d3_rwb, 0);
    rst_n = 1'b1;

    // DEPTH=1 load of a load instruction
    put(1'b1, 32'hDEADBEEF, 32'h11, 5'd5, 1'b1, 1'b1);
    fwd_rs_addr = 5'd5; fwd_rt_addr = 5'd6;
    tick();
    chk("ld_d1_ov", d1_ov, 1);
    chk("ld_d1_wb", d1_wb, 32'hDEADBEEF);
    chk("ld_d1_addr", d1_addr, 5);
    chk("ld_d1_rwb", d1_rwb, 1);
    chk("ld_d1_mr", d1_mr, 1);
    chk("ld_d1_alu", d1_alu, 32'h11);
    chk("ld_d1_mem", d1_mem, 32'hDEADBEEF);
    chk("ld_d1_rs", d1_rs, 1);
    chk("ld_d1_rt", d1_rt, 0);
    chk("ld_d3_ov_e1", d3_ov, 0);

    // invalid op to addr 7: captured but never writes or forwards
    put(1'b0, 32'h33, 32'h22, 5'd7, 1'b1, 1'b0);
    fwd_rs_addr = 5'd7; fwd_rt_addr = 5'd7;
    tick();
    chk("bub_d1_ov", d1_ov, 0);
    chk("bub_d1_rwb", d1_rwb, 0);
    chk("bub_d1_wb", d1_wb, 0);
    chk("bub_d1_addr", d1_addr, 7);
    chk("bub_d1_rs", d1_rs, 0);
    chk("bub_d1_rt", d1_rt, 0);
    chk("ld_d3_ov_e2", d3_ov, 0);
    tick();
    chk("ld_d3_ov_e3", d3_ov, 1);
    chk("ld_d3_wb", d3_wb, 32'hDEADBEEF);
    chk("ld_d3_addr", d3_addr, 5);
    chk("ld_d3_rwb", d3_rwb, 1);
    tick();
    chk("ld_d3_ov_e4", d3_ov, 0);

    // write to r0: suppressed only when ZERO_REG=1
    put(1'b1, 32'h5555, 32'h66, 5'd0, 1'b1, 1'b0);
    fwd_rs_addr = 5'd0; fwd_rt_addr = 5'd3;
    tick();
    chk("r0_d1_ov", d1_ov, 1);
    chk("r0_d1_rwb", d1_rwb, 0);
    chk("r0_d1_rs", d1_rs, 0);
    chk("r0_d1_wb", d1_wb, 32'h66);
    chk("r0_z0_rwb", z0_rwb, 1);
    chk("r0_z0_rs", z0_rs, 1);
    chk("r0_z0_rt", z0_rt, 0);

    // forwarding to both sources, then combinational change of rt address
    put(1'b1, 32'h77, 32'h88, 5'd7, 1'b1, 1'b1);
    fwd_rs_addr = 5'd7; fwd_rt_addr = 5'd7;
    tick();
    chk("fw_d1_rs", d1_rs, 1);
    chk("fw_d1_rt", d1_rt, 1);
    chk("fw_d1_wb", d1_wb, 32'h77);
    fwd_rt_addr = 5'd8;
    #1;
    chk("fw8_d1_rt", d1_rt, 0);
    chk("fw8_d1_rs", d1_rs, 1);
    put(1'b1, 32'h99, 32'hAA, 5'd7, 1'b0, 1'b0);
    tick();
    chk("norw_d1_ov", d1_ov, 1);
    chk("norw_d1_rwb", d1_rwb, 0);
    chk("norw_d1_rs", d1_rs, 0);
    chk("norw_d1_wb", d1_wb, 32'hAA);

    put(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick(); tick(); tick();

    // DEPTH=3 stream of six ALU ops with a two-cycle stall
    for (int i = 0; i < 11; i++) begin
      stall = s_stl[i];
      if (s_op[i] != 0) put_op(s_op[i]);
      else put(1'b0, '0, '0, '0, 1'b0, 1'b0);
      tick();
      chk($sformatf("st%0d_ov", i), d3_ov, s_exp[i] != 0);
      chk($sformatf("st%0d_rwb", i), d3_rwb, s_exp[i] != 0);
      chk($sformatf("st%0d_wb", i), d3_wb, (s_exp[i] != 0) ? 32'h100 + s_exp[i] : 32'h0);
      if (s_exp[i] != 0) chk($sformatf("st%0d_addr", i), d3_addr, s_exp[i]);
    end
    stall = 1'b0;

    // flush together with stall while three valid ops are in flight
    for (int unsigned op = 10; op <= 12; op++) begin
      put_op(op);
      tick();
    end
    chk("fl_pre_d3_ov", d3_ov, 1);
    chk("fl_pre_d3_addr", d3_addr, 10);
    fwd_rs_addr = 5'd10; fwd_rt_addr = 5'd12;
    stall = 1'b1; flush = 1'b1;
    put_op(13);
    tick();
    chk("fl_d3_ov", d3_ov, 0);
    chk("fl_d3_rwb", d3_rwb, 0);
    chk("fl_d3_wb", d3_wb, 0);
    chk("fl_d3_rs", d3_rs, 0);
    chk("fl_d1_ov", d1_ov, 0);
    chk("fl_d1_rt", d1_rt, 0);
    stall = 1'b0; flush = 1'b0;
    put_op(14);
    tick();
    chk("pf1_d3_ov", d3_ov, 0);
    chk("pf1_d1_ov", d1_ov, 1);
    chk("pf1_d1_addr", d1_addr, 14);
    put_op(15);
    tick();
    chk("pf2_d3_ov", d3_ov, 0);
    put_op(16);
    tick();
    chk("pf3_d3_ov", d3_ov, 1);
    chk("pf3_d3_addr", d3_addr, 14);
    chk("pf3_d3_wb", d3_wb, 32'h10E);

    // asynchronous reset in mid-stream discards in-flight ops
    put_op(17);
    tick();
    put_op(18);
    tick();
    chk("mr_pre_d3_addr", d3_addr, 16);
    rst_n = 1'b0;
    #1;
    chk("mr_d3_ov", d3_ov, 0);
    chk("mr_d3_rwb", d3_rwb, 0);
    chk("mr_d3_wb", d3_wb, 0);
    chk("mr_d1_ov", d1_ov, 0);
    #1 rst_n = 1'b1;
    put(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_post%0d_d3_ov", i), d3_ov, 0);
      chk($sformatf("mr_post%0d_d3_rwb", i), d3_rwb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
